// File: rtl/sm_hex_display_mux_pkg.sv
// Shared types and helpers for the multiplexed hex display.
package sm_hex_display_mux_pkg;

  `include "sm_display_defs.vh"

  typedef logic [6:0] seg7_t;

  // Convert an active-high segment vector to the configured pin level.
  function automatic seg7_t f_seg_level(input seg7_t s, input logic active_low);
    seg7_t r;
    if (active_low) begin
      r = ~s;
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_display_defs.vh
// Seven-segment encoding shared by the display mux and its decoder.
// Bit positions within the packed {g,f,e,d,c,b,a} vector, single-bit masks,
// and the active-high hex glyph table built from those masks.
`ifndef SM_DISPLAY_DEFS_VH
`define SM_DISPLAY_DEFS_VH

localparam int SEG_A = 0;
localparam int SEG_B = 1;
localparam int SEG_C = 2;
localparam int SEG_D = 3;
localparam int SEG_E = 4;
localparam int SEG_F = 5;
localparam int SEG_G = 6;

localparam logic [6:0] SEG_A_M = 7'b0000001 << SEG_A;
localparam logic [6:0] SEG_B_M = 7'b0000001 << SEG_B;
localparam logic [6:0] SEG_C_M = 7'b0000001 << SEG_C;
localparam logic [6:0] SEG_D_M = 7'b0000001 << SEG_D;
localparam logic [6:0] SEG_E_M = 7'b0000001 << SEG_E;
localparam logic [6:0] SEG_F_M = 7'b0000001 << SEG_F;
localparam logic [6:0] SEG_G_M = 7'b0000001 << SEG_G;

localparam logic [6:0] HEX7_0 = SEG_A_M | SEG_B_M | SEG_C_M | SEG_D_M | SEG_E_M | SEG_F_M;
localparam logic [6:0] HEX7_1 = SEG_B_M | SEG_C_M;
localparam logic [6:0] HEX7_2 = SEG_A_M | SEG_B_M | SEG_D_M | SEG_E_M | SEG_G_M;
localparam logic [6:0] HEX7_3 = SEG_A_M | SEG_B_M | SEG_C_M | SEG_D_M | SEG_G_M;
localparam logic [6:0] HEX7_4 = SEG_B_M | SEG_C_M | SEG_F_M | SEG_G_M;
localparam logic [6:0] HEX7_5 = SEG_A_M | SEG_C_M | SEG_D_M | SEG_F_M | SEG_G_M;
localparam logic [6:0] HEX7_6 = SEG_A_M | SEG_C_M | SEG_D_M | SEG_E_M | SEG_F_M | SEG_G_M;
localparam logic [6:0] HEX7_7 = SEG_A_M | SEG_B_M | SEG_C_M;
localparam logic [6:0] HEX7_8 = SEG_A_M | SEG_B_M | SEG_C_M | SEG_D_M | SEG_E_M | SEG_F_M | SEG_G_M;
localparam logic [6:0] HEX7_9 = SEG_A_M | SEG_B_M | SEG_C_M | SEG_D_M | SEG_F_M | SEG_G_M;
localparam logic [6:0] HEX7_A = SEG_A_M | SEG_B_M | SEG_C_M | SEG_E_M | SEG_F_M | SEG_G_M;
localparam logic [6:0] HEX7_B = SEG_C_M | SEG_D_M | SEG_E_M | SEG_F_M | SEG_G_M;
localparam logic [6:0] HEX7_C = SEG_A_M | SEG_D_M | SEG_E_M | SEG_F_M;
localparam logic [6:0] HEX7_D = SEG_B_M | SEG_C_M | SEG_D_M | SEG_E_M | SEG_G_M;
localparam logic [6:0] HEX7_E = SEG_A_M | SEG_D_M | SEG_E_M | SEG_F_M | SEG_G_M;
localparam logic [6:0] HEX7_F = SEG_A_M | SEG_E_M | SEG_F_M | SEG_G_M;

`endif

// File: rtl/sm_hex_display_mux_decode.sv
// Active-high hex nibble to seven-segment decoder ({g,f,e,d,c,b,a}).
module sm_hex7_decode
  import sm_hex_display_mux_pkg::*;
(
  input  logic  [3:0] i_nib,
  output seg7_t       o_seg
);

  // Look up the glyph for the nibble.
  always_comb begin
    o_seg = 7'h00;
    case (i_nib)
      4'h0:    o_seg = HEX7_0;
      4'h1:    o_seg = HEX7_1;
      4'h2:    o_seg = HEX7_2;
      4'h3:    o_seg = HEX7_3;
      4'h4:    o_seg = HEX7_4;
      4'h5:    o_seg = HEX7_5;
      4'h6:    o_seg = HEX7_6;
      4'h7:    o_seg = HEX7_7;
      4'h8:    o_seg = HEX7_8;
      4'h9:    o_seg = HEX7_9;
      4'hA:    o_seg = HEX7_A;
      4'hB:    o_seg = HEX7_B;
      4'hC:    o_seg = HEX7_C;
      4'hD:    o_seg = HEX7_D;
      4'hE:    o_seg = HEX7_E;
      4'hF:    o_seg = HEX7_F;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/sm_hex_display_mux.sv
// Time-multiplexed hex display driver with shadow/display double buffering,
// leading-zero blanking and 16-step PWM brightness. Display contents change
// only at scan wrap, so a frame never mixes old and new digits.
module sm_hex_display_mux
  import sm_hex_display_mux_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int DIV_W          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clkIn,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  update,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic              SEG_LOW  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              SDP_OFF  = SEG_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [DIV_W-1:0]    r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_sh_val;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [4*DIGITS-1:0] r_disp_val;
  logic [DIGITS-1:0]   r_disp_dp;
  logic                r_frame;
  logic [6:0]          r_seg;
  logic                r_seg_dp;
  logic [DIGITS-1:0]   r_dig;

  logic                w_tick;
  logic                w_wrap;
  logic                w_lit;
  logic [3:0]          w_nib;
  logic                w_dp_cur;
  logic                w_blank;
  logic [DIGITS-1:0]   w_dig_ah;
  seg7_t               w_seg_raw;
  logic [6:0]          w_seg_nxt;
  logic                w_sdp_nxt;
  logic [DIGITS-1:0]   w_dig_nxt;

  assign w_tick = &r_presc;
  assign w_wrap = w_tick & (r_idx == LAST_IDX);
  assign w_lit  = (r_presc[DIV_W-1 -: 4] <= brightness);

  // Free-running slot prescaler.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= {DIV_W{1'b0}};
    end else begin
      r_presc <= r_presc + DIV_W'(1'b1);
    end
  end

  // Digit index steps once per slot and wraps after the last digit.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= {IDX_W{1'b0}};
    end else if (w_tick) begin
      if (r_idx == LAST_IDX) begin
        r_idx <= {IDX_W{1'b0}};
      end else begin
        r_idx <= r_idx + IDX_W'(1'b1);
      end
    end
  end

  // Shadow register captures host writes at any time.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_val <= {(4*DIGITS){1'b0}};
      r_sh_dp  <= {DIGITS{1'b0}};
    end else if (update) begin
      r_sh_val <= value;
      r_sh_dp  <= dp;
    end
  end

  // Display register only changes at scan wrap; a write landing on that
  // same edge bypasses the shadow so it is not delayed by a whole frame.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_val <= {(4*DIGITS){1'b0}};
      r_disp_dp  <= {DIGITS{1'b0}};
    end else if (w_wrap) begin
      if (update) begin
        r_disp_val <= value;
        r_disp_dp  <= dp;
      end else begin
        r_disp_val <= r_sh_val;
        r_disp_dp  <= r_sh_dp;
      end
    end
  end

  // Frame marks the first cycle of each scan (index 0, prescaler 0).
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_wrap;
    end
  end

  // Pick the current digit's nibble/dp and decide leading-zero blanking by
  // walking from the most significant digit down.
  always_comb begin : p_select
    logic v_lz;
    v_lz     = 1'b1;
    w_nib    = 4'h0;
    w_dp_cur = 1'b0;
    w_blank  = 1'b0;
    w_dig_ah = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_lz = v_lz & (r_disp_val[4*i +: 4] == 4'h0);
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp_val[4*i +: 4];
        w_dp_cur    = r_disp_dp[i];
        w_blank     = blank_lz & v_lz & (i != 0);
        w_dig_ah[i] = 1'b1;
      end else begin
        w_nib = w_nib;
      end
    end
  end

  sm_hex7_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_seg_raw)
  );

  // Gate by the PWM window and convert to pin polarity.
  always_comb begin
    if (w_lit) begin
      w_seg_nxt = f_seg_level(w_blank ? 7'h00 : w_seg_raw, SEG_LOW);
      w_sdp_nxt = w_dp_cur ^ SDP_OFF;
      w_dig_nxt = w_dig_ah ^ DIG_OFF;
    end else begin
      w_seg_nxt = SEG_OFF;
      w_sdp_nxt = SDP_OFF;
      w_dig_nxt = DIG_OFF;
    end
  end

  // Registered pin drivers; reset forces every output to its inactive level.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= SEG_OFF;
      r_seg_dp <= SDP_OFF;
      r_dig    <= DIG_OFF;
    end else begin
      r_seg    <= w_seg_nxt;
      r_seg_dp <= w_sdp_nxt;
      r_dig    <= w_dig_nxt;
    end
  end

  assign seg    = r_seg;
  assign seg_dp = r_seg_dp;
  assign dig    = r_dig;
  assign frame  = r_frame;

endmodule

// File: tb/tb_sm_hex_display_mux.sv
// Self-checking bench: a 3-digit active-low instance and a 1-digit instance
// with active-high segments, both with 16-clock slots.
module tb_sm_hex_display_mux;

  typedef struct packed {
    logic [2:0] dig;
    logic [6:0] seg;
    logic       sdp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] value;
  logic [2:0]  dp;
  logic        update;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [2:0]  dig;
  logic        frame;

  logic [3:0]  value1;
  logic [0:0]  dp1;
  logic        update1;
  logic [6:0]  seg1;
  logic        seg_dp1;
  logic [0:0]  dig1;
  logic        frame1;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Active-high glyphs {g,f,e,d,c,b,a} written out from the segment lists.
  logic [6:0] hex7_tab [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  always #5 clk = ~clk;

  sm_hex_display_mux #(.DIGITS(3), .DIV_W(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut (
    .clkIn(clk), .rst_n(rst_n), .value(value), .dp(dp), .update(update),
    .blank_lz(blank_lz), .brightness(brightness),
    .seg(seg), .seg_dp(seg_dp), .dig(dig), .frame(frame)
  );

  sm_hex_display_mux #(.DIGITS(1), .DIV_W(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) u_dut1 (
    .clkIn(clk), .rst_n(rst_n), .value(value1), .dp(dp1), .update(update1),
    .blank_lz(blank_lz), .brightness(brightness),
    .seg(seg1), .seg_dp(seg_dp1), .dig(dig1), .frame(frame1)
  );

  // Push the 48 expected output samples of one full scan of the 3-digit DUT.
  task automatic push_frame(input logic [11:0] v, input logic [2:0] d,
                            input logic bl, input logic [3:0] br);
    exp_t e;
    logic lz;
    logic [3:0] nib;
    int di;
    int p;
    for (int k = 0; k < 48; k++) begin
      di  = k / 16;
      p   = k % 16;
      nib = v[4*di +: 4];
      lz  = bl && (di != 0);
      for (int j = di; j < 3; j++) begin
        if (v[4*j +: 4] != 4'h0) lz = 1'b0;
      end
      if (p <= int'(br)) begin
        e.dig = ~(3'b001 << di);
        e.seg = lz ? 7'h7F : ~hex7_tab[nib];
        e.sdp = ~d[di];
      end else begin
        e.dig = 3'b111;
        e.seg = 7'h7F;
        e.sdp = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_update(input logic [11:0] v, input logic [2:0] d);
    @(negedge clk);
    value  = v;
    dp     = d;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_frame(output bit found);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (frame === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dig, seg, seg_dp, frame} !== {3'b111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut: got dig=%b seg=%h dp=%b frame=%b, expected 111 7f 1 0", dig, seg, seg_dp, frame);
    end
    checks++;
    if ({dig1, seg1, seg_dp1, frame1} !== {1'b1, 7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut1: got dig=%b seg=%h dp=%b frame=%b, expected 1 00 0 0", dig1, seg1, seg_dp1, frame1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({dig, seg, seg_dp, frame} !== {3'b111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got dig=%b seg=%h dp=%b frame=%b, expected 111 7f 1 0", dig, seg, seg_dp, frame);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    bit found;
    exp_t e;
    blank_lz   = 1'b0;
    brightness = 4'd15;
    apply_update(12'h1A3, 3'b010);
    push_frame(12'h1A3, 3'b010, 1'b0, 4'd15);
    wait_frame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL scan_frame: frame=0 after 200 cycles, expected 1"); end
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({dig, seg, seg_dp} !== e) begin
        errors++;
        $display("FAIL scan k=%0d: got dig=%b seg=%h dp=%b, expected dig=%b seg=%h dp=%b", k, dig, seg, seg_dp, e.dig, e.seg, e.sdp);
      end
      checks++;
      if (frame !== (k == 47)) begin
        errors++;
        $display("FAIL scan_frame_pulse k=%0d: got %b, expected %b", k, frame, (k == 47));
      end
    end
  endtask

  task automatic test_blank();
    bit found;
    exp_t e;
    logic [11:0] vals [0:2];
    vals[0] = 12'h005;
    vals[1] = 12'h000;
    vals[2] = 12'h0A0;
    blank_lz   = 1'b1;
    brightness = 4'd15;
    for (int c = 0; c < 3; c++) begin
      apply_update(vals[c], 3'b000);
      push_frame(vals[c], 3'b000, 1'b1, 4'd15);
      wait_frame(found);
      checks++;
      if (!found) begin errors++; $display("FAIL blank_frame case=%0d: frame=0 after 200 cycles, expected 1", c); end
      for (int k = 0; k < 48; k++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({dig, seg, seg_dp} !== e) begin
          errors++;
          $display("FAIL blank v=%h k=%0d: got dig=%b seg=%h dp=%b, expected dig=%b seg=%h dp=%b", vals[c], k, dig, seg, seg_dp, e.dig, e.seg, e.sdp);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_brightness();
    bit found;
    exp_t e;
    logic [3:0] brs [0:1];
    brs[0] = 4'd3;
    brs[1] = 4'd0;
    for (int c = 0; c < 2; c++) begin
      brightness = brs[c];
      apply_update(12'h1A3, 3'b101);
      push_frame(12'h1A3, 3'b101, 1'b0, brs[c]);
      wait_frame(found);
      checks++;
      if (!found) begin errors++; $display("FAIL bright_frame br=%0d: frame=0 after 200 cycles, expected 1", brs[c]); end
      for (int k = 0; k < 48; k++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({dig, seg, seg_dp} !== e) begin
          errors++;
          $display("FAIL bright br=%0d k=%0d: got dig=%b seg=%h dp=%b, expected dig=%b seg=%h dp=%b", brs[c], k, dig, seg, seg_dp, e.dig, e.seg, e.sdp);
        end
      end
    end
    brightness = 4'd15;
  endtask

  // Write 123 mid-scan, then 456 exactly on the wrap edge.
  task automatic test_back_to_back();
    bit found;
    exp_t e;
    blank_lz   = 1'b0;
    brightness = 4'd15;
    apply_update(12'h1A3, 3'b000);
    wait_frame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_frame: frame=0 after 200 cycles, expected 1"); end
    push_frame(12'h1A3, 3'b000, 1'b0, 4'd15);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({dig, seg, seg_dp} !== e) begin
        errors++;
        $display("FAIL b2b_old k=%0d: got dig=%b seg=%h dp=%b, expected dig=%b seg=%h dp=%b", k, dig, seg, seg_dp, e.dig, e.seg, e.sdp);
      end
      update = 1'b0;
      if (k == 20) begin value = 12'h123; update = 1'b1; end
      if (k == 46) begin value = 12'h456; update = 1'b1; end
    end
    checks++;
    if (frame !== 1'b1) begin errors++; $display("FAIL b2b_wrap_frame: got %b, expected 1", frame); end
    push_frame(12'h456, 3'b000, 1'b0, 4'd15);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({dig, seg, seg_dp} !== e) begin
        errors++;
        $display("FAIL b2b_new k=%0d: got dig=%b seg=%h dp=%b, expected dig=%b seg=%h dp=%b", k, dig, seg, seg_dp, e.dig, e.seg, e.sdp);
      end
    end
  endtask

  task automatic test_single_digit();
    bit found;
    exp_t e;
    brightness = 4'd15;
    @(negedge clk);
    value1  = 4'h8;
    dp1     = 1'b1;
    update1 = 1'b1;
    @(negedge clk);
    update1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e.dig = 3'b000;
      e.seg = hex7_tab[8];
      e.sdp = 1'b1;
      exp_q.push_back(e);
    end
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (frame1 === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL single_frame: frame=0 after 100 cycles, expected 1"); end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (r == 0) begin
          e = exp_q.pop_front();
          checks++;
          if ({dig1, seg1, seg_dp1} !== {e.dig[0], e.seg, e.sdp}) begin
            errors++;
            $display("FAIL single k=%0d: got dig=%b seg=%h dp=%b, expected dig=%b seg=%h dp=%b", k, dig1, seg1, seg_dp1, e.dig[0], e.seg, e.sdp);
          end
        end
        checks++;
        if (frame1 !== (k == 15)) begin
          errors++;
          $display("FAIL single_frame_period r=%0d k=%0d: got %b, expected %b", r, k, frame1, (k == 15));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    int first;
    brightness = 4'd15;
    apply_update(12'h1A3, 3'b111);
    wait_frame(found);
    checks++;
    if (!found) begin errors++; $display("FAIL mreset_frame: frame=0 after 200 cycles, expected 1"); end
    repeat (20) @(negedge clk);
    checks++;
    if (dig !== 3'b101) begin errors++; $display("FAIL mreset_pre: got dig=%b, expected 101", dig); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dig, seg, seg_dp, frame} !== {3'b111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mreset_async: got dig=%b seg=%h dp=%b frame=%b, expected 111 7f 1 0", dig, seg, seg_dp, frame);
    end
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (frame === 1'b1 && first == 0) first = n;
    end
    checks++;
    if (first != 48) begin errors++; $display("FAIL mreset_frame_delay: got %0d, expected 48", first); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    value = 12'h000; dp = 3'b000; update = 1'b0;
    blank_lz = 1'b0; brightness = 4'd15;
    value1 = 4'h0; dp1 = 1'b0; update1 = 1'b0;
    test_reset();
    test_scan();
    test_blank();
    test_brightness();
    test_back_to_back();
    test_single_digit();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
